// File: rtl/mmss_pkg.sv
// Shared types and constants for the mm:ss stopwatch counter.
//   state_e        : control FSM states (idle, running, paused)
//   *_MAX          : largest legal value of each BCD digit
//   *_W            : bit width of each digit bus
package mmss_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } state_e;

    localparam int unsigned SEC_ONES_MAX = 9;
    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned MIN_ONES_MAX = 9;
    localparam int unsigned MIN_TENS_MAX = 5;

    localparam int unsigned SEC_ONES_W = 4;
    localparam int unsigned SEC_TENS_W = 3;
    localparam int unsigned MIN_ONES_W = 4;
    localparam int unsigned MIN_TENS_W = 3;

endpackage

// File: rtl/bcd_digit.sv
// One stage of the ripple-carry digit chain.
//   clk, rst : clock and synchronous active-high reset
//   clr      : synchronous clear to zero
//   en       : advance the digit by one this cycle
//   value    : registered digit value, 0..MAX
//   carry    : combinational, high when this advance rolls the digit over
module bcd_digit #(
    parameter int unsigned MAX = 9,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         carry
);

    // >= rather than == so an illegal out-of-range value recovers to 0 with a
    // carry on its next advance; identical to == for every reachable value.
    logic at_max;
    assign at_max = (value >= W'(MAX));
    assign carry  = en && at_max;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
        end else if (en) begin
            value <= at_max ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/mmss_counter.sv
// Minutes:seconds BCD stopwatch, 00:00..59:59 with wrap-around.
//   TICK_DIV : clock cycles per counted second (>= 2)
//   clk, rst : clock and synchronous active-high reset
//   start    : pulse, begin/resume counting
//   stop     : pulse, pause counting (beats start)
//   clear    : pulse, back to 00:00 and idle (beats everything but rst)
//   nums_*   : registered BCD digits (seconds ones/tens, minutes ones/tens)
//   running  : registered, high while counting
//   sec_tick : one-cycle pulse in the first cycle new digits are visible
//   wrap     : one-cycle pulse with the 59:59 -> 00:00 sec_tick
module mmss_counter
    import mmss_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    output logic [SEC_ONES_W-1:0] nums_0_s,
    output logic [SEC_TENS_W-1:0] nums_1_s,
    output logic [MIN_ONES_W-1:0] nums_0_m,
    output logic [MIN_TENS_W-1:0] nums_1_m,
    output logic                  running,
    output logic                  sec_tick,
    output logic                  wrap
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          in_run;
    logic          fire;
    logic          carry_0_s, carry_1_s, carry_0_m, carry_1_m;

    assign in_run = (state_q == StRun);
    // A stop or clear landing on the last prescaler cycle swallows the tick.
    assign fire   = in_run && !stop && !clear && (presc_q == PRESC_MAX);

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start && !stop) state_d = StRun;
                StRun:   if (stop) state_d = StPause;
                StPause: if (start && !stop) state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    // Prescaler holds outside RUN so a resume finishes the partial second.
    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (in_run && !stop) begin
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            running  <= 1'b0;
            sec_tick <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            running  <= (state_d == StRun);
            sec_tick <= fire;
            wrap     <= carry_1_m;
        end
    end

    bcd_digit #(
        .MAX (SEC_ONES_MAX),
        .W   (SEC_ONES_W)
    ) u_sec_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .en    (fire),
        .value (nums_0_s),
        .carry (carry_0_s)
    );

    bcd_digit #(
        .MAX (SEC_TENS_MAX),
        .W   (SEC_TENS_W)
    ) u_sec_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .en    (carry_0_s),
        .value (nums_1_s),
        .carry (carry_1_s)
    );

    bcd_digit #(
        .MAX (MIN_ONES_MAX),
        .W   (MIN_ONES_W)
    ) u_min_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .en    (carry_1_s),
        .value (nums_0_m),
        .carry (carry_0_m)
    );

    bcd_digit #(
        .MAX (MIN_TENS_MAX),
        .W   (MIN_TENS_W)
    ) u_min_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .en    (carry_0_m),
        .value (nums_1_m),
        .carry (carry_1_m)
    );

endmodule

// File: tb/tb_mmss_counter.sv
module tb_mmss_counter;

    localparam int TDIV    = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk;
    logic       rst, start, stop, clear;
    logic [3:0] nums_0_s;
    logic [2:0] nums_1_s;
    logic [3:0] nums_0_m;
    logic [2:0] nums_1_m;
    logic       running, sec_tick, wrap;

    mmss_counter #(
        .TICK_DIV (TDIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .nums_0_s (nums_0_s),
        .nums_1_s (nums_1_s),
        .nums_0_m (nums_0_m),
        .nums_1_m (nums_1_m),
        .running  (running),
        .sec_tick (sec_tick),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Reference model: elapsed seconds as a plain integer, cycles into the
    // current second, and a coarse run/idle/pause mode.
    int m_state = M_IDLE;
    int m_frac  = 0;
    int m_secs  = 0;
    int m_wraps = 0;
    int wraps_seen = 0;
    int exp_q[$];  // each entry: seconds * 2 + wrap

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int dut_secs();
        return int'(nums_1_m) * 600 + int'(nums_0_m) * 60 + int'(nums_1_s) * 10 + int'(nums_0_s);
    endfunction

    function automatic void model_step(bit s, bit p, bit c, bit r);
        if (r || c) begin
            m_state = M_IDLE;
            m_frac  = 0;
            m_secs  = 0;
        end else if (m_state == M_RUN) begin
            if (p) begin
                m_state = M_PAUSE;
            end else if (m_frac == TDIV - 1) begin
                m_frac = 0;
                m_secs = (m_secs + 1) % 3600;
                exp_q.push_back(m_secs * 2 + ((m_secs == 0) ? 1 : 0));
                if (m_secs == 0) m_wraps++;
            end else begin
                m_frac++;
            end
        end else if (s && !p) begin
            m_state = M_RUN;
        end
    endfunction

    // Drive one cycle of controls; the model then holds the post-edge state.
    task automatic cyc(input bit s, input bit p, input bit c, input bit r);
        @(negedge clk);
        start = s;
        stop  = p;
        clear = c;
        rst   = r;
        model_step(s, p, c, r);
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int secs, input int frac, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (m_state == M_RUN && m_secs == secs && m_frac == frac) begin
                hit = 1'b1;
                break;
            end
            cyc(0, 0, 0, 0);
        end
        chk(name, int'(hit), 1);
    endtask

    // Monitor: per-cycle state compare plus scoreboard pop on every tick.
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            int  e;
            bit  exp_tick;
            exp_tick = (exp_q.size() > 0);
            chk("running", int'(running), (m_state == M_RUN) ? 1 : 0);
            chk("digits", dut_secs(), m_secs);
            chk("sec_tick", int'(sec_tick), int'(exp_tick));
            if (exp_tick) begin
                e = exp_q.pop_front();
                if (sec_tick) begin
                    chk("tick_secs", dut_secs(), e / 2);
                    chk("tick_wrap", int'(wrap), e % 2);
                end
            end else begin
                chk("wrap_without_tick", int'(wrap), 0);
            end
            if (wrap) wraps_seen++;
        end
    end

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        cyc(0, 0, 0, 1);
        check_en = 1'b1;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        sample();
        chk("reset_digits", dut_secs(), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_tick", int'(sec_tick), 0);

        // Start latency and first tick.
        cyc(1, 0, 0, 0);
        sample();
        chk("start_running", int'(running), 1);
        t = 0;
        while (!sec_tick && t < 20) begin
            cyc(0, 0, 0, 0);
            sample();
            t++;
        end
        chk("first_tick_latency", t, TDIV);
        chk("first_tick_value", dut_secs(), 1);

        // Through 09:59 -> 10:00 and on to the 59:59 wrap.
        run_until(3599, TDIV - 1, "reach_5959");
        cyc(0, 0, 0, 0);
        sample();
        chk("wrap_digits", dut_secs(), 0);
        chk("wrap_pulse", int'(wrap), 1);
        chk("wrap_tick", int'(sec_tick), 1);
        chk("wrap_running", int'(running), 1);
        cyc(0, 0, 0, 0);
        sample();
        chk("wrap_one_cycle", int'(wrap), 0);

        // Pause mid-second with the prescaler at 2.
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
        sample();
        chk("pause_digits", dut_secs(), 0);
        chk("pause_running", int'(running), 0);
        cyc(1, 0, 0, 0);
        sample();
        t = 0;
        while (!sec_tick && t < 20) begin
            cyc(0, 0, 0, 0);
            sample();
            t++;
        end
        chk("resume_tick_latency", t, 2);

        // start+stop together in IDLE stays idle.
        cyc(0, 0, 1, 0);
        cyc(1, 1, 0, 0);
        sample();
        chk("start_stop_idle", int'(running), 0);

        // clear+start in PAUSE at 03:27.
        cyc(1, 0, 0, 0);
        run_until(207, 0, "reach_0327");
        cyc(0, 1, 0, 0);
        cyc(1, 0, 1, 0);
        sample();
        chk("clear_start_digits", dut_secs(), 0);
        chk("clear_start_running", int'(running), 0);

        // stop on the prescaler-wrap cycle suppresses the increment.
        cyc(1, 0, 0, 0);
        run_until(210, TDIV - 1, "reach_0330");
        cyc(0, 1, 0, 0);
        sample();
        chk("stop_on_wrap_digits", dut_secs(), 210);
        chk("stop_on_wrap_tick", int'(sec_tick), 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        sample();
        chk("resume_after_wrap_stop", dut_secs(), 211);

        // rst mid-RUN at 12:34, on a tick-due cycle.
        run_until(754, TDIV - 1, "reach_1234");
        cyc(0, 0, 0, 1);
        sample();
        chk("rst_digits", dut_secs(), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_tick", int'(sec_tick), 0);
        chk("rst_wrap", int'(wrap), 0);

        // Randomized control pulses, including overlaps.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0,
                $urandom_range(0, 79) == 0, $urandom_range(0, 299) == 0);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        sample();
        chk("queue_drained", exp_q.size(), 0);
        chk("wrap_count", wraps_seen, m_wraps);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmss_counter.md
# mmss_counter

Minutes:seconds BCD stopwatch counter that produces the four digit buses consumed by the downstream time-compare stage and the display path. It divides the system clock into a one-second tick and counts 00:00 to 59:59 with wrap-around. Start/stop/clear controls come from debounced, single-cycle button pulses. All outputs are registered.

## Interface
- `TICK_DIV`, default 50_000_000; clock cycles per second, must be ≥2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begin or resume counting.
- `stop`  in  1  single-cycle pulse; pause counting.
- `clear`  in  1  single-cycle pulse; return to 00:00, idle.
- `nums_0_s`  out  4  seconds ones digit, BCD 0–9.
- `nums_1_s`  out  3  seconds tens digit, 0–5.
- `nums_0_m`  out  4  minutes ones digit, BCD 0–9.
- `nums_1_m`  out  3  minutes tens digit, 0–5.
- `running`  out  1  high while in RUN.
- `sec_tick`  out  1  one-cycle pulse, high in the first cycle new digits are visible.
- `wrap`  out  1  one-cycle pulse coincident with the 59:59→00:00 `sec_tick`.

## Operation
- States: IDLE, RUN, PAUSE.
- Reset: state IDLE; all digits 0; prescaler 0; `running`, `sec_tick` and `wrap` 0.
- Control priority within one cycle is `clear` > `stop` > `start`.
- `clear` in any state goes to IDLE, zeroes the digits and the prescaler, and suppresses any tick due in the same cycle.
- IDLE + `start` goes to RUN. PAUSE + `start` goes to RUN.
- RUN + `stop` goes to PAUSE. The prescaler and digits hold their values in PAUSE, so resuming continues the partial second.
- Ignored controls:
  - `start` in RUN.
  - `stop` in IDLE or PAUSE.
  - `start` and `stop` together: `stop` wins. From IDLE, this leaves the block in IDLE.
- Prescaler counts 0..TICK_DIV-1, and only in RUN.
  - When the prescaler is at TICK_DIV-1 and there is no `stop` or `clear`, the increment fires and the prescaler returns to 0.
  - When `stop` arrives on that same cycle, the increment is suppressed and the prescaler holds.
- Increment chain (ripple carry):
  - `nums_0_s` 9→0 carries into `nums_1_s`.
  - `nums_1_s` 5→0 carries into `nums_0_m`.
  - `nums_0_m` 9→0 carries into `nums_1_m`.
  - `nums_1_m` 5→0 asserts `wrap`.
- Counting continues after a wrap.
- Digit widths are exact (4/3/4/3 bits). Values above the digit maximum never occur. If one does appear, the next increment forces that digit to 0 with a carry.

## Timing
- `start` sampled at edge N: `running`=1 from cycle N+1.
- First digit change is visible TICK_DIV cycles after `running` rises. `sec_tick` is high in that same cycle.
- After that, one increment every TICK_DIV cycles while in RUN. Time spent in PAUSE is excluded.
- `stop` sampled at edge N: `running`=0 from N+1, with no further increments.
- `clear` sampled at edge N: all digits read 0 and `running`=0 from N+1.
- `rst` overrides everything on the same edge, including mid-count.
- `sec_tick`/`wrap` are never high for more than one consecutive cycle.

## Structure
- Package `mmss_pkg` holds:
  - the state enum (IDLE/RUN/PAUSE);
  - digit limit constants SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9, MIN_TENS_MAX=5;
  - digit width constants.
- Sub-module `bcd_digit` has:
  - parameters MAX and W;
  - ports `clk`, `rst`, `clr`, `en`, `value`, and combinational `carry` = `en` && `value`==MAX.
- The top module instantiates four `bcd_digit` instances. It also holds the FSM, the prescaler and the pulse registers.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then `start` at cycle 0 → `running` at 1; 00:01 and `sec_tick` at cycle 5; 00:02 at cycle 9.
- Preload via 599 seconds of run to 09:59 → next tick gives 10:00, with a single `sec_tick` and no `wrap`.
- Run to 59:59 → next tick gives 00:00 with `wrap`=1 and `sec_tick`=1 for one cycle, and `running` stays 1.
- Pause mid-second:
  - `start`, then `stop` 2 cycles later, so the prescaler holds at 2.
  - Wait 20 cycles: digits unchanged.
  - `start` again: increment 2 cycles after `running` rises.
- Same-cycle controls:
  - `start`+`stop` in IDLE → stays IDLE.
  - `clear`+`start` in PAUSE at 03:27 → IDLE, 00:00.
  - `stop` on the prescaler-wrap cycle → no increment.
- Assert `rst` mid-RUN at 12:34 → next cycle all digits 0, `running`=0, with no `sec_tick`/`wrap` pulse.
